// File: rtl/spike_snippet_extractor_pkg.sv
// spike_pkg: shared sample/timestamp types and state encoding for the spike processing chain
package spike_pkg;
   localparam int DATA_W = 16;
   localparam int TS_W = 32;
   localparam int DET_LAT_DEF = 3;
   typedef logic signed [DATA_W-1:0] sample_t;
   typedef logic [TS_W-1:0] ts_t;
   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
endpackage

// File: rtl/spike_snippet_extractor_if.sv
// spike_snippet_extractor_if: snippet output stream with valid/ready handshake
interface spike_snippet_extractor_if;
   import spike_pkg::*;
   sample_t data;
   logic valid;
   logic ready;
   logic first;
   logic last;
   ts_t ts;
   modport master(output data, valid, first, last, ts, input ready);
   modport slave(input data, valid, first, last, ts, output ready);
endinterface

// File: rtl/spike_snippet_extractor_sample_ring.sv
// sample_ring: circular sample history with one write port and a registered read port
module sample_ring
   import spike_pkg::*;
#(
   parameter int AW = 5
) (
   input logic clk,
   input logic rst,
   input logic [AW-1:0] wr_addr,
   input sample_t wr_data,
   input logic [AW-1:0] rd_addr,
   output sample_t rd_data
);
   sample_t mem [1<<AW];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
         rd_data <= '0;
      end else begin
         mem[wr_addr] <= wr_data;
         rd_data <= mem[rd_addr];
      end
   end
endmodule

// File: rtl/spike_snippet_extractor.sv
// spike_snippet_extractor: captures a PRE/POST sample window around each accepted spike
// and streams it out tagged with the trigger sample index.
module spike_snippet_extractor
   import spike_pkg::*;
#(
   parameter int PRE = 8,
   parameter int POST = 24,
   parameter int DET_LAT = DET_LAT_DEF,
   parameter int RING_AW = 5,
   parameter int REFRACT = 100
) (
   input logic clk,
   input logic rst,
   input sample_t data_in,
   input logic spike_in,
   spike_snippet_extractor_if.master out,
   output logic [15:0] drop_count,
   output logic busy
);
   localparam int WIN = PRE + POST;
   localparam int KW = $clog2(WIN);
   if ((1 << RING_AW) < PRE + DET_LAT + 2) begin : g_ring_check
      $error("history ring too shallow for PRE + DET_LAT");
   end
   state_t state;
   ts_t n;
   logic spike_q;
   logic [31:0] refr;
   logic [RING_AW-1:0] start;
   logic [KW-1:0] cap_k, rd_k, k;
   logic rd_vld;
   sample_t rd_data;
   sample_t snip [WIN];
   logic trig, accept;
   ts_t trig_ts;
   assign trig = spike_in && !spike_q;
   // refr is checked before this cycle's decrement, so a count of 1 has already expired
   assign accept = trig && state == IDLE && refr < 32'd2;
   assign trig_ts = n - ts_t'(DET_LAT);
   assign busy = state != IDLE;
   sample_ring #(.AW(RING_AW)) u_ring (
      .clk(clk),
      .rst(rst),
      .wr_addr(n[RING_AW-1:0]),
      .wr_data(data_in),
      .rd_addr(start + RING_AW'(cap_k)),
      .rd_data(rd_data)
   );
   always_ff @(posedge clk)
      if (state == CAPTURE && rd_vld) snip[rd_k] <= rd_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         n <= '0;
         spike_q <= 1'b0;
         refr <= '0;
         drop_count <= '0;
         start <= '0;
         cap_k <= '0;
         rd_k <= '0;
         rd_vld <= 1'b0;
         k <= '0;
         out.valid <= 1'b0;
         out.data <= '0;
         out.first <= 1'b0;
         out.last <= 1'b0;
         out.ts <= '0;
      end else begin
         n <= n + 1'b1;
         spike_q <= spike_in;
         refr <= accept ? 32'(REFRACT) : refr - 32'(refr != '0);
         if (trig && !accept && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
         rd_vld <= state == CAPTURE;
         rd_k <= cap_k;
         case (state)
            IDLE: if (accept) begin
               state <= CAPTURE;
               start <= RING_AW'(trig_ts - ts_t'(PRE));
               out.ts <= trig_ts;
               cap_k <= '0;
            end
            CAPTURE: begin
               cap_k <= cap_k + 1'b1;
               if (rd_vld && rd_k == KW'(WIN - 1)) begin
                  state <= DRAIN;
                  k <= '0;
               end
            end
            DRAIN: if (!out.valid) begin
               out.valid <= 1'b1;
               out.data <= snip[k];
               out.first <= k == '0;
               out.last <= k == KW'(WIN - 1);
            end else if (out.ready) begin
               if (out.last) begin
                  state <= IDLE;
                  out.valid <= 1'b0;
                  out.first <= 1'b0;
                  out.last <= 1'b0;
               end else begin
                  k <= k + 1'b1;
                  out.data <= snip[k + 1'b1];
                  out.first <= 1'b0;
                  out.last <= k + 1'b1 == KW'(WIN - 1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
